// File: rtl/joypad_pkg.sv
// joypad_pkg: shared constants for the NES joypad port.
// Button bit indices and shift counter sizing.
package joypad_pkg;

  localparam int NUM_BUTTONS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int SHIFT_CNT_W = 4;

  localparam logic [SHIFT_CNT_W-1:0] SHIFT_CNT_MAX =
    SHIFT_CNT_W'(NUM_BUTTONS);

endpackage

// File: rtl/joypad_debounce.sv
// joypad_debounce: 2-flop synchronizer plus debounce counter.
// stable follows raw once it has differed for DEBOUNCE_CYCLES.
module joypad_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  logic        s1;
  logic        s2;
  logic [15:0] cnt;

  // bring the asynchronous input into the clk domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // count disagreement cycles, commit when the run is long enough
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= 16'd0;
      stable <= 1'b0;
    end else if (s2 == stable) begin
      cnt <= 16'd0;
    end else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
      stable <= s2;
      cnt    <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/joypad_port.sv
// joypad_port: NES controller responder (strobe latch, serial out).
// Optional turbo A/B oscillator when JOYPAD_TURBO_EN is defined.
module joypad_port
  import joypad_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] TURBO_DIV       = 24'd357954
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] buttons_i,
  input  logic [1:0]             turbo_i,
  input  logic                   strobe_i,
  input  logic                   shift_i,
  output logic                   data_o,
  output logic [NUM_BUTTONS-1:0] buttons_o
);

  logic [NUM_BUTTONS-1:0] load_value;
  logic [NUM_BUTTONS-1:0] sr;
  logic [SHIFT_CNT_W-1:0] shift_cnt;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    joypad_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (buttons_i[i]),
      .stable(buttons_o[i])
    );
  end

`ifdef JOYPAD_TURBO_EN
  logic [1:0]  t;
  logic [23:0] div;
  logic        phase;

  for (genvar j = 0; j < 2; j++) begin : g_turbo
    joypad_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (turbo_i[j]),
      .stable(t[j])
    );
  end

  // free-running oscillator; phase flips on every divider wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div   <= 24'd0;
      phase <= 1'b0;
    end else if (div == TURBO_DIV - 24'd1) begin
      div   <= 24'd0;
      phase <= ~phase;
    end else begin
      div <= div + 24'd1;
    end
  end

  // turbo only ORs into A and B; debug view stays raw
  always_comb begin
    load_value        = buttons_o;
    load_value[BTN_A] = buttons_o[BTN_A] | (t[0] & phase);
    load_value[BTN_B] = buttons_o[BTN_B] | (t[1] & phase);
  end
`else
  logic unused_turbo;
  assign unused_turbo = ^turbo_i;

  // no turbo: latch exactly what the player holds
  always_comb begin
    load_value = buttons_o;
  end
`endif

  // strobe reloads and wins over shift; shift fills with 1s
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr        <= '0;
      shift_cnt <= '0;
    end else if (strobe_i) begin
      sr        <= load_value;
      shift_cnt <= '0;
    end else if (shift_i) begin
      sr <= {1'b1, sr[NUM_BUTTONS-1:1]};
      if (shift_cnt != SHIFT_CNT_MAX)
        shift_cnt <= shift_cnt + 1'b1;
    end
  end

  assign data_o = sr[0];

endmodule

// File: tb/tb_joypad_port.sv
// tb_joypad_port: directed self-checking bench for joypad_port.
// Runs with DEBOUNCE_CYCLES=4, TURBO_DIV=8.
module tb_joypad_port;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] buttons_i;
  logic [1:0] turbo_i;
  logic       strobe_i;
  logic       shift_i;
  logic       data_o;
  logic [7:0] buttons_o;

  int total = 0;
  int fails = 0;

  joypad_port #(
    .DEBOUNCE_CYCLES(16'd4),
    .TURBO_DIV      (24'd8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .buttons_i(buttons_i),
    .turbo_i  (turbo_i),
    .strobe_i (strobe_i),
    .shift_i  (shift_i),
    .data_o   (data_o),
    .buttons_o(buttons_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  logic [9:0] rd_seq;
  logic [7:0] sim_seq;
  logic [8:0] rr_seq;
  int         last_t;
  int         ntog;
  logic       prev_d;

  initial begin
    rst       = 1'b0;
    buttons_i = 8'hFF;
    turbo_i   = 2'b00;
    strobe_i  = 1'b0;
    shift_i   = 1'b0;

    // reset held: outputs stay clear
    repeat (3) begin
      @(negedge clk);
      chk("rst_data", 16'(data_o), 16'h0);
      chk("rst_btn", 16'(buttons_o), 16'h00);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("deb_5cyc", 16'(buttons_o), 16'h00);
    @(negedge clk);
    chk("deb_6cyc", 16'(buttons_o), 16'hFF);

    // readout 8'b1000_0101, 10 back-to-back reads
    buttons_i = 8'h85;
    repeat (8) @(negedge clk);
    chk("btn_85", 16'(buttons_o), 16'h85);
    strobe_i = 1'b1;
    @(negedge clk);
    strobe_i = 1'b0;
    rd_seq = 10'b11_1000_0101;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("read_%0d", i), 16'(data_o),
          16'(rd_seq[i]));
      shift_i = 1'b1;
      @(negedge clk);
    end
    shift_i = 1'b0;

    // strobe held high: shifts ignored, A tracks debounced
    strobe_i = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      shift_i = 1'b1;
      @(negedge clk);
      chk($sformatf("strb_a_%0d", i), 16'(data_o), 16'h1);
    end
    shift_i = 1'b0;
    buttons_i = 8'h84;
    repeat (6) @(negedge clk);
    chk("strb_btn_84", 16'(buttons_o), 16'h84);
    @(negedge clk);
    chk("strb_a_drop", 16'(data_o), 16'h0);

    // 3-cycle glitch on Select never reaches buttons_o
    strobe_i = 1'b0;
    buttons_i = 8'h80;
    repeat (8) @(negedge clk);
    chk("btn_80", 16'(buttons_o), 16'h80);
    buttons_i = 8'h84;
    repeat (3) @(negedge clk);
    buttons_i = 8'h80;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("glitch_%0d", i), 16'(buttons_o), 16'h80);
    end

    // strobe and shift together: reload wins
    strobe_i = 1'b1;
    @(negedge clk);
    strobe_i = 1'b0;
    shift_i = 1'b1;
    repeat (3) @(negedge clk);
    shift_i = 1'b0;
    chk("cnt_3", 16'(dut.shift_cnt), 16'h3);
    strobe_i = 1'b1;
    shift_i = 1'b1;
    @(negedge clk);
    strobe_i = 1'b0;
    shift_i = 1'b0;
    chk("sim_cnt0", 16'(dut.shift_cnt), 16'h0);
    sim_seq = 8'h80;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("sim_rd_%0d", i), 16'(data_o),
          16'(sim_seq[i]));
      shift_i = 1'b1;
      @(negedge clk);
    end
    shift_i = 1'b0;
    chk("cnt_sat", 16'(dut.shift_cnt), 16'h8);

    // asynchronous reset in the middle of a read
    buttons_i = 8'h8D;
    repeat (8) @(negedge clk);
    chk("btn_8d", 16'(buttons_o), 16'h8D);
    strobe_i = 1'b1;
    @(negedge clk);
    strobe_i = 1'b0;
    shift_i = 1'b1;
    repeat (3) @(negedge clk);
    shift_i = 1'b0;
    chk("mid_pre", 16'(data_o), 16'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_data", 16'(data_o), 16'h0);
    chk("mid_rst_btn", 16'(buttons_o), 16'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_btn", 16'(buttons_o), 16'h8D);
    strobe_i = 1'b1;
    @(negedge clk);
    strobe_i = 1'b0;
    rr_seq = 9'h18D;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("post_rd_%0d", i), 16'(data_o),
          16'(rr_seq[i]));
      shift_i = 1'b1;
      @(negedge clk);
    end
    shift_i = 1'b0;

    // turbo A with buttons idle, strobe held high
    buttons_i = 8'h00;
    turbo_i = 2'b01;
    repeat (8) @(negedge clk);
    chk("btn_idle", 16'(buttons_o), 16'h00);
    strobe_i = 1'b1;
`ifdef JOYPAD_TURBO_EN
    last_t = -1;
    ntog = 0;
    @(negedge clk);
    prev_d = data_o;
    for (int i = 1; i < 41; i++) begin
      @(negedge clk);
      if (data_o !== prev_d) begin
        if (last_t >= 0)
          chk("turbo_period", 16'(i - last_t), 16'd8);
        last_t = i;
        ntog++;
      end
      prev_d = data_o;
    end
    chk("turbo_toggles", 16'(ntog >= 4), 16'h1);
`else
    last_t = 0;
    ntog = 0;
    prev_d = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk($sformatf("noturbo_%0d", i), 16'(data_o), 16'h0);
    end
`endif
    strobe_i = 1'b0;

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected done");
    $fatal(1);
  end

endmodule
